// File: rtl/flag_event_monitor.sv
// flag_event_monitor: registered stage for the ok/event flag decoder.
// Pulses on event rises, counts them, and latches a sustained-fault alarm.
module flag_event_monitor #(
  parameter int CNT_W     = 8,
  parameter int ALARM_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             y1_in,
  input  logic             y2_in,
  output logic             evt_pulse,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             cnt_sat,
  output logic             alarm
);

  localparam int RW = $clog2(ALARM_LEN + 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(ALARM_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOW   = 2'd1,
    ALARM = 2'd2
  } state_t;

  logic y1_q;
  logic y2_q;
  logic y2_d;
  logic rise;

  state_t state;
  state_t state_nxt;
  logic [RW-1:0] run;
  logic [RW-1:0] run_nxt;

  assign rise  = y2_q & ~y2_d;
  assign alarm = (state == ALARM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y1_q      <= 1'b1;
      y2_q      <= 1'b0;
      y2_d      <= 1'b0;
      evt_pulse <= 1'b0;
    end else begin
      y1_q      <= y1_in;
      y2_q      <= y2_in;
      y2_d      <= y2_q;
      evt_pulse <= rise;
    end
  end

  // Saturating counter; clr wins over a coincident rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt <= '0;
      cnt_sat <= 1'b0;
    end else if (clr) begin
      evt_cnt <= '0;
      cnt_sat <= 1'b0;
    end else if (rise && evt_cnt != CNT_MAX) begin
      evt_cnt <= evt_cnt + 1'b1;
      if (evt_cnt == CNT_PRE) cnt_sat <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      run   <= '0;
    end else begin
      state <= state_nxt;
      run   <= run_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    if (clr) begin
      state_nxt = IDLE;
      run_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!y1_q) begin
            state_nxt = LOW;
            run_nxt   = RW'(1);
          end else begin
            run_nxt = '0;
          end
        end
        LOW: begin
          if (y1_q) begin
            state_nxt = IDLE;
            run_nxt   = '0;
          end else if (run == RUN_LAST) begin
            state_nxt = ALARM;
          end else begin
            run_nxt = run + 1'b1;
          end
        end
        ALARM: begin
          state_nxt = ALARM;
        end
        default: begin
          state_nxt = IDLE;
          run_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flag_event_monitor.sv
// tb_flag_event_monitor: directed vector table plus hand sequences
// for reset, saturation, clear and alarm corner cases.
module tb_flag_event_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       y1_in;
  logic       y2_in;
  logic       evt_pulse;
  logic [2:0] evt_cnt;
  logic       cnt_sat;
  logic       alarm;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       clr;
    logic       y1;
    logic       y2;
    logic       pulse;
    logic [2:0] cnt;
    logic       sat;
    logic       alarm;
  } vec_t;

  vec_t tbl[$];

  flag_event_monitor #(
    .CNT_W    (3),
    .ALARM_LEN(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .y1_in    (y1_in),
    .y2_in    (y2_in),
    .evt_pulse(evt_pulse),
    .evt_cnt  (evt_cnt),
    .cnt_sat  (cnt_sat),
    .alarm    (alarm)
  );

  always #5 clk = ~clk;

  function automatic void add(
    input logic c, input logic a, input logic b,
    input logic p, input logic [2:0] n,
    input logic s, input logic al
  );
    vec_t v;
    v.clr = c; v.y1 = a; v.y2 = b;
    v.pulse = p; v.cnt = n; v.sat = s; v.alarm = al;
    tbl.push_back(v);
  endfunction

  task automatic check(
    input string name,
    input logic [5:0] act,
    input logic [5:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (pulse,cnt,sat,alarm)",
               name, act, exp);
    end
  endtask

  task automatic cyc(input logic c, input logic a, input logic b);
    @(negedge clk);
    clr = c; y1_in = a; y2_in = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] outs();
    return {evt_pulse, evt_cnt, cnt_sat, alarm};
  endfunction

  initial begin
    // Rise, 5-wide level, 1-low gap, 1-wide pulse -> two events.
    add(0,1,1, 0,0,0,0);
    add(0,1,1, 1,1,0,0);
    add(0,1,1, 0,1,0,0);
    add(0,1,1, 0,1,0,0);
    add(0,1,1, 0,1,0,0);
    add(0,1,0, 0,1,0,0);
    add(0,1,1, 0,1,0,0);
    add(0,1,0, 1,2,0,0);
    add(0,1,0, 0,2,0,0);
    // Three low samples: no alarm.
    add(0,0,0, 0,2,0,0);
    add(0,0,0, 0,2,0,0);
    add(0,0,0, 0,2,0,0);
    add(0,1,0, 0,2,0,0);
    add(0,1,0, 0,2,0,0);
    add(0,1,0, 0,2,0,0);
    // Four low samples: alarm one edge after the 4th, then sticky.
    add(0,0,0, 0,2,0,0);
    add(0,0,0, 0,2,0,0);
    add(0,0,0, 0,2,0,0);
    add(0,0,0, 0,2,0,0);
    add(0,1,0, 0,2,0,1);
    add(0,1,0, 0,2,0,1);
    add(0,1,0, 0,2,0,1);
    // Three more isolated events -> count 5 with alarm held.
    for (int k = 3; k <= 5; k++) begin
      add(0,1,1, 0,3'(k-1),0,1);
      add(0,1,0, 1,3'(k),0,1);
    end
    // clr coincident with a detected rise.
    add(0,1,1, 0,5,0,1);
    add(1,1,0, 1,0,0,0);
    add(0,1,0, 0,0,0,0);
    // Nine isolated events: saturate at 7, no wrap.
    for (int k = 1; k <= 9; k++) begin
      add(0,1,1, 0,3'((k-1 > 7) ? 7 : k-1),(k-1 >= 7),0);
      add(0,1,0, 1,3'((k > 7) ? 7 : k),(k >= 7),0);
    end
    add(1,1,0, 0,0,0,0);

    rst_n = 1'b0; clr = 1'b0; y1_in = 1'b1; y2_in = 1'b0;
    #1;
    check("reset_state", outs(), 6'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].clr, tbl[i].y1, tbl[i].y2);
      check($sformatf("vec%0d", i), outs(),
            {tbl[i].pulse, tbl[i].cnt, tbl[i].sat, tbl[i].alarm});
    end

    // Async reset mid-stream with pulse, count and alarm all set.
    cyc(0,0,0);
    cyc(0,0,0);
    cyc(0,0,0);
    cyc(0,0,1);
    cyc(0,0,0);
    check("pre_async_rst", outs(), {1'b1, 3'd1, 1'b0, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", outs(), 6'b0);
    @(negedge clk);
    y1_in = 1'b1;
    rst_n = 1'b1;

    // Reset while in LOW with run=3: needs 4 fresh low samples.
    cyc(0,0,0);
    cyc(0,0,0);
    cyc(0,0,0);
    cyc(0,0,0);
    check("low_run3", outs(), 6'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (k >= 4)
        check($sformatf("fresh_low_e%0d", k), outs(),
              {5'b0, (k == 5)});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
